msg_drop_scheduler: RTL

Policy controller that drives the `drop` input of `msg_dropper`. It snoops the Avalon-ST handshake at the dropper input and decides, per message, whether that message is dropped. It supports pass-all, drop-all, drop-one-in-N and token-bucket rate limiting, and holds each decision stable for the whole message. It sits beside `msg_dropper`, with its `drop` output wired straight to the dropper.

---
 rtl/msg_drop_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/msg_drop_scheduler.sv
// msg_drop_scheduler: per-message drop policy controller driving msg_dropper.drop
// Snoops the msg_in Avalon-ST handshake (mon_*) and commits one drop decision per
// message at SOP accept, frozen until EOP accept.
// Policies (cfg_mode): 0 pass-all, 1 drop-all, 2 one-in-cfg_period, 3 token bucket
// (cfg_burst capacity, cfg_refill tokens every cfg_interval cycles).
// Ports: clk, rst_n (async active-low); mon_valid/ready/sop/eop snooped beats;
// cfg_* policy config; cfg_load reloads bucket, timer and message index;
// stat_clr clears statistics; drop to dropper; tokens bucket level;
// drop_cnt/pass_cnt saturating message statistics.
// Optional: define MSG_DROP_SCHED_STATS_EN to build the statistics counters,
// otherwise drop_cnt/pass_cnt read 0 and stat_clr is ignored.
module msg_drop_scheduler #(
  parameter int TOK_W = 16,
  parameter int TMR_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_valid,
  input  logic             mon_ready,
  input  logic             mon_sop,
  input  logic             mon_eop,
  input  logic [1:0]       cfg_mode,
  input  logic [TOK_W-1:0] cfg_period,
  input  logic [TOK_W-1:0] cfg_refill,
  input  logic [TMR_W-1:0] cfg_interval,
  input  logic [TOK_W-1:0] cfg_burst,
  input  logic             cfg_load,
  input  logic             stat_clr,
  output logic             drop,
  output logic [TOK_W-1:0] tokens,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] pass_cnt
);
  typedef enum logic {IDLE, IN_MSG} state_t;
  state_t state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [TOK_W-1:0] idx, idx_nxt, tok_nxt;
  logic [TOK_W:0] tok_sum, tok_cap;
  logic acc, sop_acc, eop_acc, commit, wrap, consume, decide, drop_nxt;
  assign acc = mon_valid & mon_ready;
  assign sop_acc = acc & mon_sop;
  assign eop_acc = acc & mon_eop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Non-SOP beats in IDLE and SOP beats in IN_MSG are protocol errors and ignored.
  always_comb begin
    state_nxt = state;
    commit = 1'b0;
    if (state == IDLE) begin
      commit = sop_acc;
      state_nxt = (sop_acc && !eop_acc) ? IN_MSG : IDLE;
    end else if (eop_acc && !mon_sop) state_nxt = IDLE;
  end
  assign wrap = (cfg_interval != '0) && (timer >= cfg_interval - TMR_W'(1));
  assign timer_nxt = (cfg_load || wrap || cfg_interval == '0) ? '0 : timer + TMR_W'(1);
  // A pass in mode 3 normally sees a nonzero bucket; the guard covers the one-cycle
  // lag after a switch into mode 3 so the bucket never underflows.
  assign consume = commit & ~drop & (cfg_mode == 2'd3) & (tokens != '0);
  // One extra bit so refill on top of a nearly full bucket cannot wrap before the cap.
  assign tok_sum = {1'b0, tokens} - (TOK_W+1)'(consume) + (wrap ? {1'b0, cfg_refill} : '0);
  assign tok_cap = (tok_sum > {1'b0, cfg_burst}) ? {1'b0, cfg_burst} : tok_sum;
  assign tok_nxt = cfg_load ? cfg_burst : wrap ? tok_cap[TOK_W-1:0] : tok_sum[TOK_W-1:0];
  assign idx_nxt = cfg_load ? '0 :
                   !commit ? idx :
                   (cfg_period <= TOK_W'(1) || idx >= cfg_period - TOK_W'(1)) ? '0 :
                   idx + TOK_W'(1);
  // Decision is taken on the post-update bucket/index so back-to-back messages see
  // the effect of the previous commit.
  assign decide = (cfg_mode == 2'd0) ? 1'b0 :
                  (cfg_mode == 2'd1) ? 1'b1 :
                  (cfg_mode == 2'd2) ? (cfg_period != '0 && idx_nxt == cfg_period - TOK_W'(1)) :
                  (tok_nxt == '0);
  assign drop_nxt = (state_nxt == IDLE) ? decide : drop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drop <= 1'b0;
      tokens <= '0;
      timer <= '0;
      idx <= '0;
    end else begin
      drop <= drop_nxt;
      tokens <= tok_nxt;
      timer <= timer_nxt;
      idx <= idx_nxt;
    end
`ifdef MSG_DROP_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drop_cnt <= '0;
      pass_cnt <= '0;
    end else begin
      drop_cnt <= stat_clr ? '0 : (commit && drop && !(&drop_cnt)) ? drop_cnt + CNT_W'(1) : drop_cnt;
      pass_cnt <= stat_clr ? '0 : (commit && !drop && !(&pass_cnt)) ? pass_cnt + CNT_W'(1) : pass_cnt;
    end
`else
  logic stats_unused;
  assign stats_unused = stat_clr;
  assign drop_cnt = '0;
  assign pass_cnt = '0;
`endif
endmodule
